pt5_stream_packer: RTL and testbench
====================================

PT5_STREAM_PACKER -- requirements
Module: pt5_stream_packer

Interface
REQ-001 SHALL have parameter CNT_W, 16, width of the emitted-byte counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port trit_in  input  2  trit code: 0=-1, 1=0, 2=+1, 3=illegal.
REQ-005 SHALL have port trit_valid  input  1  trit_in/flush qualified.
REQ-006 SHALL have port trit_ready  output  1  packer accepts on this cycle.
REQ-007 SHALL have port flush  input  1  with trit_valid: close the partial group after this beat.
REQ-008 SHALL have port packed_byte  output  8  packed group, value 0..242.
REQ-009 SHALL have port packed_valid  output  1  packed_byte qualified.
REQ-010 SHALL have port packed_ready  input  1  downstream (pt5_unpacker feeder) accepts.
REQ-011 SHALL have port err_illegal  output  1  sticky: illegal code 3 was accepted.
REQ-012 SHALL have port byte_count  output  CNT_W  bytes handed off, wraps modulo 2^CNT_W.

Function
REQ-013 SHALL pack five trits as packed_byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4, t0 the first accepted trit, matching pt5_unpacker trit0..trit4 ordering.
REQ-014 SHALL transfer an input beat when trit_valid and trit_ready are both high; output beat when packed_valid and packed_ready are both high.
REQ-015 SHALL drive trit_ready = !(packed_valid && !packed_ready), combinationally; no other backpressure source.
REQ-016 SHALL accumulate incrementally: 8-bit accumulator plus 3-bit position counter (0..4) and running weight (1,3,9,27,81); no multiplier wider than 8x2.
REQ-017 SHALL, on the beat carrying position 4, load acc+t*81 into the output register, set packed_valid next cycle, and clear accumulator/position the same edge (latency 1 cycle from fifth trit to packed_valid).
REQ-018 SHALL hold packed_byte stable while packed_valid && !packed_ready.
REQ-019 SHALL clear packed_valid after an output beat unless a new group completes on the same edge, in which case packed_valid stays high with the new byte (back-to-back, full throughput of one byte per five trits).
REQ-020 SHALL treat accepted code 3 as code 1 (value 0) and set err_illegal, which remains set until reset.
REQ-021 SHALL, on an accepted beat with flush=1, include that beat's trit, then pad remaining positions with code 1 and emit the padded byte as in REQ-017.
REQ-022 SHALL emit nothing for flush when the flush beat's trit completes a full group (emits that group only) — i.e. never an all-padding byte.
REQ-023 SHALL ignore flush and trit_in when the beat is not accepted.
REQ-024 SHALL increment byte_count by one per output beat, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-025 SHALL on rst_n low immediately force packed_valid=0, packed_byte=0, err_illegal=0, byte_count=0, accumulator=0, position=0, weight=1.
REQ-026 SHALL discard any partial group or pending output on reset mid-operation; first trit after release is t0 of a new group.
REQ-027 SHALL present trit_ready=1 during and immediately after reset.

Structure
REQ-028 SHALL take trit code constants (TRIT_NEG=0, TRIT_ZERO=1, TRIT_POS=2, TRIT_ILL=3), PT5_TRITS=5, PT5_MAX=242 and the padding table (sum of 3^k for k>=pos: 121,120,117,108,81) from a shared pt5 package also used by pt5_unpacker.
REQ-029 SHALL be a single module with no sub-modules; the output holding register is internal, not a separate FIFO instance.

Verification
REQ-030 SHALL check codes 0,0,0,0,0 -> one byte 0x00; codes 2,2,2,2,2 -> 0xF2; codes 1,1,1,1,1 -> 0x79.
REQ-031 SHALL check codes 2,0,1,0,0 -> 0x0B; then codes 2,2 with flush on second -> 0x7D; byte_count=2.
REQ-032 SHALL check packed_ready held low 20 cycles with 10 trits offered -> exactly 5 accepted then trit_ready=0, packed_byte stable; release -> two bytes in order, no loss.
REQ-033 SHALL check code 3 inside group 3,1,1,1,1 -> 0x79 and err_illegal=1 persisting until rst_n pulse.
REQ-034 SHALL check rst_n pulse after 3 trits then codes 2,1,1,1,1 -> 0x7A, byte_count=1.
REQ-035 SHALL loop all 243 groups through packer into pt5_unpacker -> every decoded trit equals the driven trit.

Source files
------------

// File: rtl/pt5_pkg.sv
// Shared balanced-ternary (pt5) definitions used by pt5_stream_packer and pt5_unpacker.
// Holds the trit code map, group size, and the padding table used when a partial group is flushed.
package pt5_pkg;

  localparam int         PT5_TRITS = 5;
  localparam logic [7:0] PT5_MAX   = 8'd242;

  localparam logic [1:0] TRIT_NEG  = 2'd0;
  localparam logic [1:0] TRIT_ZERO = 2'd1;
  localparam logic [1:0] TRIT_POS  = 2'd2;
  localparam logic [1:0] TRIT_ILL  = 2'd3;

  typedef logic [2:0] pos_t;

  localparam pos_t PT5_LAST_POS = pos_t'(PT5_TRITS - 1);

  // Value of filling positions pos..4 with TRIT_ZERO (digit 1): sum of 3^k for k >= pos.
  function automatic logic [7:0] pt5_pad(input pos_t pos);
    case (pos)
      3'd0:    return 8'd121;
      3'd1:    return 8'd120;
      3'd2:    return 8'd117;
      3'd3:    return 8'd108;
      3'd4:    return 8'd81;
      default: return 8'd0;
    endcase
  endfunction

  // The illegal code carries no value; it is folded onto the zero trit.
  function automatic logic [1:0] trit_digit(input logic [1:0] code);
    return (code == TRIT_ILL) ? TRIT_ZERO : code;
  endfunction

endpackage

// File: rtl/pt5_stream_packer.sv
// Packs a stream of trits, five per byte (t0 + 3*t1 + ... + 81*t4), with flush-and-pad
// of partial groups, a single-entry output holding register and a sticky illegal-code flag.
module pt5_stream_packer
  import pt5_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       trit_in,
  input  logic             trit_valid,
  output logic             trit_ready,
  input  logic             flush,
  output logic [7:0]       packed_byte,
  output logic             packed_valid,
  input  logic             packed_ready,
  output logic             err_illegal,
  output logic [CNT_W-1:0] byte_count
);

  logic [7:0] acc;
  logic [7:0] weight;
  pos_t       pos;

  logic       in_fire;
  logic       out_fire;
  logic       close_group;
  logic [1:0] digit;
  logic [7:0] term;
  logic [7:0] sum;
  logic [7:0] group_byte;

  // Only a full, unconsumed output register stalls the input side.
  assign trit_ready = !(packed_valid && !packed_ready);
  assign in_fire    = trit_valid && trit_ready;
  assign out_fire   = packed_valid && packed_ready;

  assign digit = trit_digit(trit_in);

  // digit * weight as shift-add; digit <= 2 and the running sum never exceeds 242.
  assign term  = (digit[1] ? {weight[6:0], 1'b0} : 8'd0) + (digit[0] ? weight : 8'd0);
  assign sum   = acc + term;

  assign close_group = in_fire && ((pos == PT5_LAST_POS) || flush);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    group_byte = sum;
    if (pos != PT5_LAST_POS) begin
      group_byte = sum + pt5_pad(pos + 3'd1);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= 8'd0;
      weight       <= 8'd1;
      pos          <= '0;
      packed_byte  <= 8'd0;
      packed_valid <= 1'b0;
      err_illegal  <= 1'b0;
      byte_count   <= '0;
    end else begin
      if (out_fire) begin
        packed_valid <= 1'b0;
        byte_count   <= byte_count + 1'b1;
      end

      if (in_fire && (trit_in == TRIT_ILL)) begin
        err_illegal <= 1'b1;
      end

      // A completing group overrides the clear above, giving back-to-back output beats.
      if (close_group) begin
        packed_byte  <= group_byte;
        packed_valid <= 1'b1;
        acc          <= 8'd0;
        weight       <= 8'd1;
        pos          <= '0;
      end else if (in_fire) begin
        acc    <= sum;
        weight <= weight + {weight[6:0], 1'b0};
        pos    <= pos + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pt5_stream_packer.sv
// Directed bench for pt5_stream_packer: hand-computed groups, flush/pad, backpressure,
// illegal codes, reset mid-group, and a round trip of all 243 group values.
module tb_pt5_stream_packer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       trit_in;
  logic             trit_valid;
  logic             trit_ready;
  logic             flush;
  logic [7:0]       packed_byte;
  logic             packed_valid;
  logic             packed_ready;
  logic             err_illegal;
  logic [CNT_W-1:0] byte_count;

  pt5_stream_packer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trit_in      (trit_in),
    .trit_valid   (trit_valid),
    .trit_ready   (trit_ready),
    .flush        (flush),
    .packed_byte  (packed_byte),
    .packed_valid (packed_valid),
    .packed_ready (packed_ready),
    .err_illegal  (err_illegal),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] outq [$];

  // Inputs change on the falling edge; output beats are recorded just before the rising edge.
  always @(negedge clk) begin
    #3;
    if (rst_n && packed_valid && packed_ready) outq.push_back(packed_byte);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    trit_valid = 1'b0;
    flush      = 1'b0;
    trit_in    = 2'd0;
  endtask

  // Call on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic send_trit(input logic [1:0] code, input logic fl);
    int n = 0;
    trit_valid = 1'b1;
    trit_in    = code;
    flush      = fl;
    #1;
    while (!trit_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!trit_ready) check("send_timeout", 32'(trit_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_group(input logic [1:0] c0, c1, c2, c3, c4);
    send_trit(c0, 1'b0);
    send_trit(c1, 1'b0);
    send_trit(c2, 1'b0);
    send_trit(c3, 1'b0);
    send_trit(c4, 1'b0);
    idle();
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (outq.size() == 0 && n < 40) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (outq.size() == 0) check({tag, "_timeout"}, 32'(outq.size()), 32'd1);
    else check(tag, 32'(outq.pop_front()), 32'(exp));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check("ready_in_reset", 32'(trit_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    outq.delete();
  endtask

  logic [1:0] bp [10];
  logic [1:0] dg [5];
  logic [9:0] exp_digits [$];

  initial begin
    int idx;
    logic rdy;
    idle();
    packed_ready = 1'b1;
    rst_n        = 1'b1;

    // Reset state
    do_reset();
    #1;
    check("rst_packed_valid", 32'(packed_valid), 32'd0);
    check("rst_packed_byte",  32'(packed_byte),  32'd0);
    check("rst_err_illegal",  32'(err_illegal),  32'd0);
    check("rst_byte_count",   32'(byte_count),   32'd0);
    check("rst_trit_ready",   32'(trit_ready),   32'd1);
    @(negedge clk);

    // All-plus group, with one-cycle latency to packed_valid
    send_group(2'd2, 2'd2, 2'd2, 2'd2, 2'd2);
    check("latency_valid", 32'(packed_valid), 32'd1);
    check("latency_byte",  32'(packed_byte),  32'hF2);
    expect_byte("grp_all_pos", 8'hF2);
    send_group(2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    expect_byte("grp_all_neg", 8'h00);
    send_group(2'd1, 2'd1, 2'd1, 2'd1, 2'd1);
    expect_byte("grp_all_zero", 8'h79);
    repeat (2) @(negedge clk);
    check("count_after_3", 32'(byte_count), 32'd3);

    // Mixed group, then flushed partial group padded with zero trits
    do_reset();
    @(negedge clk);
    send_group(2'd2, 2'd0, 2'd1, 2'd0, 2'd0);
    expect_byte("grp_mixed", 8'h0B);
    send_trit(2'd2, 1'b0);
    send_trit(2'd2, 1'b1);
    idle();
    expect_byte("flush_pad", 8'h7D);
    repeat (2) @(negedge clk);
    check("count_after_flush", 32'(byte_count), 32'd2);

    // Flush on the fifth trit emits just the full group, no padding byte
    send_trit(2'd2, 1'b0);
    send_trit(2'd0, 1'b0);
    send_trit(2'd2, 1'b0);
    send_trit(2'd0, 1'b0);
    send_trit(2'd2, 1'b1);
    idle();
    expect_byte("flush_full", 8'hB6);
    repeat (4) @(negedge clk);
    check("flush_full_no_extra", 32'(outq.size()), 32'd0);
    check("count_after_full_flush", 32'(byte_count), 32'd3);

    // Backpressure: 20 stalled cycles with 10 trits offered
    bp = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    packed_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      trit_valid = (idx < 10);
      trit_in    = bp[(idx < 10) ? idx : 0];
      flush      = 1'b0;
      #1;
      rdy = trit_ready;
      @(posedge clk);
      if (rdy && idx < 10) idx++;
      @(negedge clk);
      if (c == 8) check("bp_byte_mid", 32'(packed_byte), 32'h07);
    end
    check("bp_accepted", 32'(idx), 32'd5);
    #1;
    check("bp_ready_low", 32'(trit_ready), 32'd0);
    check("bp_byte_end", 32'(packed_byte), 32'h07);
    check("bp_no_output", 32'(outq.size()), 32'd0);
    @(negedge clk);
    packed_ready = 1'b1;
    for (int i = 5; i < 10; i++) send_trit(bp[i], 1'b0);
    idle();
    expect_byte("bp_first", 8'h07);
    expect_byte("bp_second", 8'hA2);

    // Illegal code folds to zero and latches the sticky flag until reset
    do_reset();
    @(negedge clk);
    send_group(2'd3, 2'd1, 2'd1, 2'd1, 2'd1);
    expect_byte("illegal_group", 8'h79);
    check("err_set", 32'(err_illegal), 32'd1);
    send_group(2'd0, 2'd2, 2'd0, 2'd0, 2'd0);
    expect_byte("after_illegal", 8'h06);
    check("err_sticky", 32'(err_illegal), 32'd1);
    do_reset();
    #1;
    check("err_cleared", 32'(err_illegal), 32'd0);
    @(negedge clk);

    // Reset in the middle of a group discards the partial trits
    send_trit(2'd2, 1'b0);
    send_trit(2'd2, 1'b0);
    send_trit(2'd2, 1'b0);
    idle();
    do_reset();
    @(negedge clk);
    send_group(2'd2, 2'd1, 2'd1, 2'd1, 2'd1);
    expect_byte("after_mid_reset", 8'h7A);
    repeat (2) @(negedge clk);
    check("count_mid_reset", 32'(byte_count), 32'd1);

    // Round trip of every group value, sent back to back, decoded digit by digit
    do_reset();
    @(negedge clk);
    for (int v = 0; v < 243; v++) begin
      int t = v;
      for (int k = 0; k < 5; k++) begin
        dg[k] = 2'(t % 3);
        t     = t / 3;
      end
      exp_digits.push_back({dg[4], dg[3], dg[2], dg[1], dg[0]});
      for (int k = 0; k < 5; k++) send_trit(dg[k], 1'b0);
    end
    idle();
    repeat (4) @(negedge clk);
    check("rt_count", 32'(outq.size()), 32'd243);
    for (int v = 0; v < 243 && outq.size() > 0; v++) begin
      logic [7:0] b;
      logic [9:0] got;
      int         r;
      b = outq.pop_front();
      r = int'(b);
      for (int k = 0; k < 5; k++) begin
        got[2*k +: 2] = 2'(r % 3);
        r = r / 3;
      end
      if (b > 8'd242) got = 10'h3FF;
      check($sformatf("rt_%0d", v), 32'(got), 32'(exp_digits[v]));
    end
    check("rt_byte_count", 32'(byte_count), 32'd243);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
